axi_lite_reg_slave: RTL
=======================

# axi_lite_reg_slave

AXI4-Lite responder terminating the register bus driven by the PCIe bridge. Decodes a fixed word-addressed map of ID, scratch, control and status registers and returns OKAY/SLVERR responses with one-outstanding-transaction-per-direction semantics. It sits in the `aclk` domain directly below the PCIe-to-AXI4-Lite path and drives the design's control vectors.

## Interface
- `NCTRL`, 4: number of 32-bit read/write control registers.
- `NSTAT`, 4: number of 32-bit read-only status registers.
- `ID_VALUE`, 32'hFB00_0001: constant returned at word 0.
- `aclk`  in  1: single clock for all logic.
- `areset`  in  1: asynchronous, active-high reset.
- `axi`  `axi4_lite_if.s`  32-bit data: AXI4-Lite slave port. Only `addr[11:2]` is decoded, and `prot` is ignored.
- `ctrl_o`  out  NCTRL*32: control register contents. Register i occupies bits [32i+31:32i].
- `status_i`  in  NSTAT*32: live status words, synchronous to `aclk`.
- `irq_i`  in  32: interrupt event pulses (only with `AXI_SLV_IRQ_EN`).
- `irq_o`  out  1: OR of the pending bits (only with `AXI_SLV_IRQ_EN`).

## Operation
Word map, with idx = addr[11:2]:
- idx 0, ID: read-only, returns `ID_VALUE`.
- idx 1, SCRATCH: read/write, resets to 0.
- idx 2 to 1+NCTRL, CTRL[i]: read/write, resets to 0.
- idx 2+NCTRL to 1+NCTRL+NSTAT, STATUS[j]: read-only, returns `status_i` sampled at AR handshake.
- idx 2+NCTRL+NSTAT, IRQ_PEND: write-1-to-clear, resets to 0. Present only with `AXI_SLV_IRQ_EN`.
- Writes to read-only words are ignored and respond OKAY.
- Any other idx: writes are ignored, reads return 32'hDEAD_BEEF, and both respond SLVERR (2'b10).
- `wstrb[k]` gates byte k on RW words and on W1C clears. Write with `wstrb` = 0: no change, response OKAY.

Write FSM states:
- W_COLLECT: AW and W are accepted independently, in any order.
  - `awready` = 1 while no address is held; `wready` = 1 while no data is held.
  - Each accepted channel is latched and its ready drops.
- The edge on which both are held, or on which both handshake together, commits the write, sets `bvalid`, and moves to W_RESP.
- W_RESP: `awready` = `wready` = 0. `bvalid` holds with a stable `bresp` until `bready`, then returns to W_COLLECT.

Read FSM states:
- R_IDLE: `arready` = 1. On AR handshake, decode and register `rdata`/`rresp`, set `rvalid`, go to R_DATA.
- R_DATA: `arready` = 0. Hold until `rready`, then return to R_IDLE.

Simultaneous events:
- Read and write commit to the same word on the same edge: the read returns the pre-write value.
- Read and write FSMs are fully independent. No channel waits on the other direction.
- IRQ_PEND, `irq_i` bit set and W1C clear of the same bit on the same edge: the set wins.

## Timing
- Reset values (asynchronous, immediate): all readies 0, `bvalid` 0, `rvalid` 0, `bresp` 0, `rresp` 0, `rdata` 0, `ctrl_o` 0, `irq_o` 0, all registers 0.
- First cycle after `areset` falls: `awready`, `wready`, `arready` = 1. They are registered, never combinational from `valid`.
- Write latency: `bvalid` is visible in the cycle after the final AW/W handshake. The register value is visible on `ctrl_o` in that same cycle.
- Read latency: `rvalid`/`rdata` are visible in the cycle after the AR handshake.
- Back-to-back throughput: one transaction per 2 cycles per direction when `bready`/`rready` are held high.
- `areset` mid-transaction: pending responses are dropped and state returns to W_COLLECT/R_IDLE. The master must also be reset.

## Configuration
- `AXI_SLV_IRQ_EN` defined:
  - The IRQ_PEND word exists.
  - Each bit is set on `irq_i` high, with an edge count of at least 1 cycle.
  - The bit clears on a write-1.
  - `irq_o` is registered and equals |IRQ_PEND.
- Undefined: the IRQ_PEND idx decodes as unmapped (SLVERR), `irq_i` is unused, `irq_o` is tied 0.

## Test plan
- Reset release, then read idx 0 → `rdata` = 32'hFB00_0001, `rresp` = OKAY, `rvalid` exactly 1 cycle after AR handshake.
- W to SCRATCH 2 cycles before AW, data 32'h1234_5678, `wstrb` 4'b0101, then read SCRATCH → 32'h0034_0078; `bvalid` 1 cycle after the AW handshake.
- Write CTRL[1] = 32'hA5A5_A5A5 with `bready` held low 5 cycles → `bvalid` stable 5 cycles, `awready`/`wready` 0 throughout, `ctrl_o[63:32]` = 32'hA5A5_A5A5.
- Read and write to idx 0x3FF → `rresp` = 2'b10 with `rdata` 32'hDEAD_BEEF, `bresp` = 2'b10, all registers unchanged.
- AR handshake to CTRL[0] on the same edge as a write commit of 32'h1 to CTRL[0] (previously 0) → read returns 0, then a re-read returns 1.
- With `AXI_SLV_IRQ_EN`: pulse `irq_i[3]` → `irq_o` = 1. Write-1 bit 3 while pulsing `irq_i[3]` on the same edge → the bit stays set. A clean W1C → `irq_o` = 0 the next cycle.

Source files
------------

// File: rtl/axi_lite_reg_slave_if.sv
// axi4_lite_if: AXI4-Lite bundle shared by the PCIe bridge (master side) and
// the register responder (slave side).
//   modport s : responder view (addresses/data/valids in, readies/responses out)
//   modport m : master view (mirror of s)
interface axi4_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport s (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

  modport m (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave: AXI4-Lite register responder below the PCIe bridge.
// Word map (idx = addr[11:2]):
//   0                     ID        (RO, ID_VALUE)
//   1                     SCRATCH   (RW)
//   2 .. 1+NCTRL          CTRL[i]   (RW, driven on ctrl_o)
//   2+NCTRL .. 1+NCTRL+NSTAT  STATUS[j] (RO, status_i sampled at AR handshake)
//   2+NCTRL+NSTAT         IRQ_PEND  (W1C, only when AXI_SLV_IRQ_EN is defined)
//   anything else         SLVERR, reads return 32'hDEAD_BEEF
// Ports:
//   aclk, areset  clock, asynchronous active-high reset
//   axi           AXI4-Lite slave port (addr[11:2] decoded, prot ignored)
//   ctrl_o        CTRL register contents, register i at [32i+31:32i]
//   status_i      live status words
//   irq_i         interrupt event pulses (used only with AXI_SLV_IRQ_EN)
//   irq_o         OR of pending bits (tied 0 without AXI_SLV_IRQ_EN)
//
// FSMs:
//   state     | meaning
//   W_COLLECT | gathering AW and W independently; commit once both are held
//   W_RESP    | bvalid asserted, waiting for bready
//   R_IDLE    | arready high, waiting for an AR handshake
//   R_DATA    | rvalid asserted, waiting for rready
module axi_lite_reg_slave #(
  parameter int          NCTRL    = 4,
  parameter int          NSTAT    = 4,
  parameter logic [31:0] ID_VALUE = 32'hFB00_0001
) (
  input  logic                aclk,
  input  logic                areset,
  axi4_lite_if.s              axi,
  output logic [NCTRL*32-1:0] ctrl_o,
  input  logic [NSTAT*32-1:0] status_i,
  input  logic [31:0]         irq_i,
  output logic                irq_o
);

  localparam int IDX_SCRATCH = 1;
  localparam int IDX_CTRL0   = 2;
  localparam int IDX_STAT0   = 2 + NCTRL;
  localparam int IDX_IRQ     = 2 + NCTRL + NSTAT;
`ifdef AXI_SLV_IRQ_EN
  localparam bit IRQ_PRESENT = 1'b1;
`else
  localparam bit IRQ_PRESENT = 1'b0;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_COLLECT, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA}    r_state_t;

  function automatic logic [31:0] byte_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{strb[k]}};
    return m;
  endfunction

  function automatic logic idx_mapped(input logic [9:0] idx);
    return (int'(idx) < IDX_IRQ) || (IRQ_PRESENT && (int'(idx) == IDX_IRQ));
  endfunction

  // ---------------------------------------------------------------- write path
  w_state_t           w_state_q, w_state_d;
  logic               awready_q, awready_d;
  logic               wready_q, wready_d;
  logic               bvalid_q, bvalid_d;
  logic [1:0]         bresp_q, bresp_d;
  logic               aw_held_q, aw_held_d;
  logic               w_held_q, w_held_d;
  logic [9:0]         aw_idx_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wstrb_q;
  logic               aw_hs, w_hs, have_aw, have_w, w_commit;
  logic [9:0]         w_idx;
  logic [31:0]        w_data, w_mask;
  logic [3:0]         w_strb;

  assign aw_hs   = axi.awvalid & awready_q;
  assign w_hs    = axi.wvalid & wready_q;
  assign have_aw = aw_held_q | aw_hs;
  assign have_w  = w_held_q | w_hs;

  // A channel that was latched on an earlier edge takes priority over the bus,
  // whose value is only meaningful during its own handshake.
  assign w_idx  = aw_held_q ? aw_idx_q : axi.awaddr[11:2];
  assign w_data = w_held_q ? wdata_q : axi.wdata;
  assign w_strb = w_held_q ? wstrb_q : axi.wstrb;
  assign w_mask = byte_mask(w_strb);

  always_comb begin
    w_state_d = w_state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    w_commit  = 1'b0;
    case (w_state_q)
      W_COLLECT: begin
        if (have_aw && have_w) begin
          w_commit  = 1'b1;
          w_state_d = W_RESP;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bvalid_d  = 1'b1;
          bresp_d   = idx_mapped(w_idx) ? RESP_OKAY : RESP_SLVERR;
        end else begin
          if (aw_hs) aw_held_d = 1'b1;
          if (w_hs)  w_held_d  = 1'b1;
          // Also raises the readies on the first edge after reset.
          awready_d = ~aw_held_d;
          wready_d  = ~w_held_d;
        end
      end
      W_RESP: begin
        if (axi.bready) begin
          bvalid_d  = 1'b0;
          w_state_d = W_COLLECT;
          awready_d = 1'b1;
          wready_d  = 1'b1;
        end
      end
      default: w_state_d = W_COLLECT;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_q <= W_COLLECT;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (aw_hs) aw_idx_q <= axi.awaddr[11:2];
      if (w_hs) begin
        wdata_q <= axi.wdata;
        wstrb_q <= axi.wstrb;
      end
    end
  end

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;

  // ------------------------------------------------------------ register file
  logic [31:0]         scratch_q;
  logic [NCTRL*32-1:0] ctrl_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      scratch_q <= '0;
      ctrl_q    <= '0;
    end else if (w_commit) begin
      if (int'(w_idx) == IDX_SCRATCH)
        scratch_q <= (scratch_q & ~w_mask) | (w_data & w_mask);
      for (int i = 0; i < NCTRL; i++) begin
        if (int'(w_idx) == IDX_CTRL0 + i)
          ctrl_q[32*i +: 32] <= (ctrl_q[32*i +: 32] & ~w_mask) | (w_data & w_mask);
      end
    end
  end

  assign ctrl_o = ctrl_q;

  logic [31:0] irq_pend_q;
`ifdef AXI_SLV_IRQ_EN
  logic [31:0] irq_pend_d, irq_clr;
  logic        irq_o_q;

  // New events are OR-ed in after the clear so a same-edge set wins.
  always_comb begin
    irq_clr = '0;
    if (w_commit && (int'(w_idx) == IDX_IRQ)) irq_clr = w_data & w_mask;
    irq_pend_d = (irq_pend_q & ~irq_clr) | irq_i;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      irq_pend_q <= '0;
      irq_o_q    <= 1'b0;
    end else begin
      irq_pend_q <= irq_pend_d;
      irq_o_q    <= |irq_pend_d;
    end
  end

  assign irq_o = irq_o_q;
`else
  logic unused_irq;
  assign unused_irq = ^irq_i;
  assign irq_pend_q = '0;
  assign irq_o      = 1'b0;
`endif

  // ----------------------------------------------------------------- read path
  r_state_t    r_state_q, r_state_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic        r_load;
  logic [31:0] rdata_q, rd_word;
  logic [1:0]  rresp_q;
  logic        rd_err;
  int          ar_i;

  assign ar_i = int'(axi.araddr[11:2]);

  always_comb begin
    rd_word = 32'hDEAD_BEEF;
    rd_err  = 1'b1;
    if (ar_i == 0) begin
      rd_word = ID_VALUE;
      rd_err  = 1'b0;
    end else if (ar_i == IDX_SCRATCH) begin
      rd_word = scratch_q;
      rd_err  = 1'b0;
    end else if (IRQ_PRESENT && (ar_i == IDX_IRQ)) begin
      rd_word = irq_pend_q;
      rd_err  = 1'b0;
    end
    for (int i = 0; i < NCTRL; i++) begin
      if (ar_i == IDX_CTRL0 + i) begin
        rd_word = ctrl_q[32*i +: 32];
        rd_err  = 1'b0;
      end
    end
    for (int j = 0; j < NSTAT; j++) begin
      if (ar_i == IDX_STAT0 + j) begin
        rd_word = status_i[32*j +: 32];
        rd_err  = 1'b0;
      end
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    r_load    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (axi.arvalid && arready_q) begin
          r_load    = 1'b1;
          r_state_d = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
        end
      end
      R_DATA: begin
        if (axi.rready) begin
          r_state_d = R_IDLE;
          arready_d = 1'b1;
          rvalid_d  = 1'b0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      if (r_load) begin
        rdata_q <= rd_word;
        rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;

  logic unused_bits;
  assign unused_bits = ^{axi.awaddr[31:12], axi.awaddr[1:0], axi.araddr[31:12],
                         axi.araddr[1:0], axi.awprot, axi.arprot};

endmodule
